// File: rtl/bench_pkg.sv
// ----------------------------------------------------------------------------
// bench_pkg
// Shared definitions for the bench sweeper: FSM state encoding, opcode and
// operand widths, the program-table entry layout and an index-width helper.
// ----------------------------------------------------------------------------
package bench_pkg;

    localparam int OPCODE_W  = 4;
    localparam int OPERAND_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_NEXT_OP,
        S_NEXT_COND,
        S_FINAL,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [OPCODE_W-1:0]  opcode;
        logic [OPERAND_W-1:0] a;
        logic [OPERAND_W-1:0] b;
    } prog_entry_t;

    // Width of an index into n entries; never narrower than one bit so that
    // single-entry tables still get a legal port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bench_sweeper_if.sv
// ----------------------------------------------------------------------------
// bench_sweeper_if
// Request/completion handshake between the sweeper and the device being
// characterised.
//   dut_start  : one-cycle request strobe (sweeper -> device)
//   dut_cond   : condition index of the request
//   dut_opcode : operation code from the program table
//   dut_a/b    : operands from the program table
//   dut_done   : completion pulse (device -> sweeper)
// Modports: master = sweeper side, slave = device side.
// ----------------------------------------------------------------------------
interface bench_sweeper_if #(
    parameter int COND_W = 2
);
    import bench_pkg::*;

    logic                 dut_start;
    logic [COND_W-1:0]    dut_cond;
    logic [OPCODE_W-1:0]  dut_opcode;
    logic [OPERAND_W-1:0] dut_a;
    logic [OPERAND_W-1:0] dut_b;
    logic                 dut_done;

    modport master (
        output dut_start, dut_cond, dut_opcode, dut_a, dut_b,
        input  dut_done
    );

    modport slave (
        input  dut_start, dut_cond, dut_opcode, dut_a, dut_b,
        output dut_done
    );

endinterface

// File: rtl/bench_argmin.sv
// ----------------------------------------------------------------------------
// bench_argmin
// Combinational minimum finder over N unsigned values. Among equal minima the
// highest index wins.
//   vals       : input, N values of W bits
//   min_idx    : output, index of the winning entry
//   min_onehot : output, one-hot form of min_idx
// ----------------------------------------------------------------------------
module bench_argmin #(
    parameter int N     = 4,
    parameter int W     = 32,
    parameter int IDX_W = 2
) (
    input  logic [W-1:0]     vals [N],
    output logic [IDX_W-1:0] min_idx,
    output logic [N-1:0]     min_onehot
);

    logic [W-1:0] best;

    // NOTE: combinational blocks use blocking '=' so later statements see the
    // value just computed (the running minimum here); clocked blocks use '<='.
    always_comb begin
        best    = vals[0];
        min_idx = '0;
        // '<=' rather than '<' lets a later equal value take over the win.
        for (int i = 1; i < N; i++) begin
            if (vals[i] <= best) begin
                best    = vals[i];
                min_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            min_onehot[i] = (min_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/bench_sweeper.sv
// ----------------------------------------------------------------------------
// bench_sweeper
// Sweeps a small program of operations across NUM_COND operating conditions,
// measures cycles each condition needs to complete the program REPEAT times,
// and reports the fastest condition.
//   clk, rst          : clock, synchronous active-high reset
//   start, abort      : begin a sweep / terminate a sweep (abort has priority)
//   prog_we/addr/op/a/b : program-table write port (accepted when not busy)
//   dut               : request/completion handshake (master side)
//   busy, done        : sweep in progress / results valid
//   timeout_err       : sticky, some condition exceeded TIMEOUT on an op
//   winner_idx/onehot : fastest condition (onehot is zero while done=0)
//   rd_cond/rd_cycles : combinational readout of a condition's total
// ----------------------------------------------------------------------------
module bench_sweeper
    import bench_pkg::*;
#(
    parameter  int NUM_COND = 4,
    parameter  int NUM_OPS  = 9,
    parameter  int REPEAT   = 1,
    parameter  int TIMEOUT  = 1024,
    parameter  int CNT_W    = 32,
    localparam int COND_W   = idx_w(NUM_COND),
    localparam int OP_W     = idx_w(NUM_OPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 prog_we,
    input  logic [OP_W-1:0]      prog_addr,
    input  logic [OPCODE_W-1:0]  prog_op,
    input  logic [OPERAND_W-1:0] prog_a,
    input  logic [OPERAND_W-1:0] prog_b,
    bench_sweeper_if.master      dut,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic [COND_W-1:0]    winner_idx,
    output logic [NUM_COND-1:0]  winner_onehot,
    input  logic [COND_W-1:0]    rd_cond,
    output logic [CNT_W-1:0]     rd_cycles
);

    localparam int PASS_W = idx_w(REPEAT);
    localparam int TMO_W  = idx_w(TIMEOUT);

    state_t               state, state_n;
    prog_entry_t          prog_tbl [NUM_OPS];
    logic [CNT_W-1:0]     total    [NUM_COND];
    logic [CNT_W-1:0]     acc;
    logic [COND_W-1:0]    cond_idx;
    logic [OP_W-1:0]      op_idx;
    logic [PASS_W-1:0]    pass_idx;
    logic [TMO_W-1:0]     wait_cnt;
    logic                 cond_invalid;
    logic [NUM_COND-1:0]  onehot_q;
    logic [COND_W-1:0]    amin_idx;
    logic [NUM_COND-1:0]  amin_onehot;

    logic last_op, last_pass, last_cond, wait_expired;

    assign last_op      = (op_idx   == OP_W'(NUM_OPS - 1));
    assign last_pass    = (pass_idx == PASS_W'(REPEAT - 1));
    assign last_cond    = (cond_idx == COND_W'(NUM_COND - 1));
    // True in the TIMEOUT-th WAIT cycle of the current op.
    assign wait_expired = (wait_cnt == TMO_W'(TIMEOUT - 1));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_n       = state;
        busy          = (state != S_IDLE) && (state != S_DONE);
        // Gated by rst/abort so no request escapes in a reset or abort cycle.
        dut.dut_start = (state == S_ISSUE) && !abort && !rst;

        unique case (state)
            S_IDLE, S_DONE: if (start) state_n = S_LOAD;
            S_LOAD:         state_n = S_ISSUE;
            S_ISSUE:        state_n = S_WAIT;
            S_WAIT: begin
                if (dut.dut_done)      state_n = S_NEXT_OP;
                else if (wait_expired) state_n = S_NEXT_COND;
            end
            S_NEXT_OP:      state_n = (last_op && last_pass) ? S_NEXT_COND : S_LOAD;
            S_NEXT_COND:    state_n = last_cond ? S_FINAL : S_LOAD;
            S_FINAL:        state_n = S_DONE;
            default:        state_n = S_IDLE;
        endcase

        if (abort) state_n = S_IDLE;
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the program table is a reset register file, not a RAM,
            // because a reset must leave every entry reading back as zero.
            for (int i = 0; i < NUM_OPS; i++)  prog_tbl[i] <= '0;
            for (int c = 0; c < NUM_COND; c++) total[c]    <= '0;
            acc            <= '0;
            cond_idx       <= '0;
            op_idx         <= '0;
            pass_idx       <= '0;
            wait_cnt       <= '0;
            cond_invalid   <= 1'b0;
            done           <= 1'b0;
            timeout_err    <= 1'b0;
            winner_idx     <= '0;
            onehot_q       <= '0;
            dut.dut_cond   <= '0;
            dut.dut_opcode <= '0;
            dut.dut_a      <= '0;
            dut.dut_b      <= '0;
        end else begin
            if (prog_we && !busy && (int'(prog_addr) < NUM_OPS)) begin
                prog_tbl[prog_addr] <= '{opcode: prog_op, a: prog_a, b: prog_b};
            end

            if (abort) begin
                done <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            for (int c = 0; c < NUM_COND; c++) total[c] <= '0;
                            acc          <= '0;
                            cond_idx     <= '0;
                            op_idx       <= '0;
                            pass_idx     <= '0;
                            cond_invalid <= 1'b0;
                            timeout_err  <= 1'b0;
                            done         <= 1'b0;
                        end
                    end
                    S_LOAD: begin
                        dut.dut_opcode <= prog_tbl[op_idx].opcode;
                        dut.dut_a      <= prog_tbl[op_idx].a;
                        dut.dut_b      <= prog_tbl[op_idx].b;
                        dut.dut_cond   <= cond_idx;
                        wait_cnt       <= '0;
                    end
                    S_WAIT: begin
                        if (!(&acc)) acc <= acc + 1'b1;   // saturate, never wrap
                        wait_cnt <= wait_cnt + 1'b1;
                        if (!dut.dut_done && wait_expired) begin
                            timeout_err     <= 1'b1;
                            cond_invalid    <= 1'b1;
                            total[cond_idx] <= '1;
                        end
                    end
                    S_NEXT_OP: begin
                        if (last_op) begin
                            op_idx <= '0;
                            if (last_pass) total[cond_idx] <= cond_invalid ? '1 : acc;
                            else           pass_idx <= pass_idx + 1'b1;
                        end else begin
                            op_idx <= op_idx + 1'b1;
                        end
                    end
                    S_NEXT_COND: begin
                        if (!last_cond) begin
                            cond_idx     <= cond_idx + 1'b1;
                            op_idx       <= '0;
                            pass_idx     <= '0;
                            acc          <= '0;
                            cond_invalid <= 1'b0;
                        end
                    end
                    S_FINAL: begin
                        winner_idx <= amin_idx;
                        onehot_q   <= amin_onehot;
                        done       <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    bench_argmin #(
        .N     (NUM_COND),
        .W     (CNT_W),
        .IDX_W (COND_W)
    ) u_argmin (
        .vals       (total),
        .min_idx    (amin_idx),
        .min_onehot (amin_onehot)
    );

    assign winner_onehot = done ? onehot_q : '0;

    always_comb begin
        rd_cycles = '0;
        if (int'(rd_cond) < NUM_COND) rd_cycles = total[rd_cond];
    end

endmodule

// File: doc/bench_sweeper.md
BENCH_SWEEPER -- requirements
Module: bench_sweeper

Interface
REQ-001 Parameter NUM_COND, default 4, number of conditions swept (2..8).
REQ-002 Parameter NUM_OPS, default 9, program table depth (1..16).
REQ-003 Parameter REPEAT, default 1, passes of the op list per condition (1..15).
REQ-004 Parameter TIMEOUT, default 1024, max WAIT cycles per op before abandon.
REQ-005 Parameter CNT_W, default 32, cycle accumulator width.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 Port clk, input, 1, sole clock.
REQ-008 Port rst, input, 1, synchronous active-high reset.
REQ-009 Port start, input, 1, one-cycle pulse beginning a sweep.
REQ-010 Port abort, input, 1, terminate sweep.
REQ-011 Ports prog_we/prog_addr/prog_op/prog_a/prog_b, input, 1/clog2(NUM_OPS)/4/16/16, program table write.
REQ-012 Ports dut_start/dut_cond/dut_opcode/dut_a/dut_b, output, 1/clog2(NUM_COND)/4/16/16, DUT request.
REQ-013 Port dut_done, input, 1, DUT completion pulse.
REQ-014 Ports busy, done, timeout_err, output, 1 each, status.
REQ-015 Ports winner_idx/winner_onehot, output, clog2(NUM_COND)/NUM_COND, result.
REQ-016 Ports rd_cond input clog2(NUM_COND) and rd_cycles output CNT_W, combinational total readout.

Function
REQ-017 States IDLE, LOAD, ISSUE, WAIT, NEXT_OP, NEXT_COND, FINAL, DONE.
REQ-018 IDLE/DONE + start: clear all totals, cond/op/pass indices, timeout_err, done; go LOAD.
REQ-019 LOAD: register table[op] onto dut_opcode/a/b, cond index onto dut_cond; go ISSUE.
REQ-020 ISSUE: dut_start high exactly one cycle; go WAIT; dut_start low in all other states.
REQ-021 WAIT: accumulator +1 every cycle including the cycle dut_done is seen; dut_done -> NEXT_OP.
REQ-022 Accumulator saturates at all-ones, never wraps.
REQ-023 WAIT reaching TIMEOUT cycles without dut_done: set timeout_err (sticky), mark condition invalid, go NEXT_COND skipping remaining ops/passes.
REQ-024 NEXT_OP: advance op; after last op advance pass; after last pass store accumulator (or all-ones if invalid) into total[cond], go NEXT_COND; else LOAD.
REQ-025 NEXT_COND: last condition -> FINAL; else cond+1, op/pass/accumulator cleared, LOAD.
REQ-026 FINAL: latch argmin of totals into winner_idx/winner_onehot, done=1, go DONE.
REQ-027 Argmin tie-break: highest index wins among equal minima.
REQ-028 winner_onehot is all-zero whenever done=0; winner_idx holds last value.
REQ-029 busy=1 in LOAD..FINAL, 0 in IDLE/DONE.
REQ-030 start while busy ignored; prog_we while busy ignored; prog_we in IDLE/DONE writes next cycle.
REQ-031 abort (any state, priority over start): next state IDLE, done=0, totals held, dut_start=0.
REQ-032 dut_done outside WAIT ignored.
REQ-033 rd_cycles = total[rd_cond]; rd_cond >= NUM_COND returns 0.

Reset
REQ-034 Reset: state IDLE, all outputs 0, totals 0, indices 0, program table entries all zero.
REQ-035 Reset mid-sweep discards the run; no dut_start issued in the reset cycle or the one after.

Structure
REQ-036 Package bench_pkg holds state encoding, opcode width 4, operand width 16.
REQ-037 Sub-module bench_argmin: combinational NUM_COND-input minimum with high-index tie-break.

Verification
REQ-038 Stub DUT latency per cond {3,5,2,7}, NUM_OPS=2, REPEAT=1 -> totals {6,10,4,14}, winner_idx=2, onehot 0100.
REQ-039 All latencies 4 -> totals all 8, winner_idx=3.
REQ-040 TIMEOUT=16, cond1 never completes -> total[1]=all-ones, timeout_err=1, winner from others.
REQ-041 REPEAT=3, latency 2, NUM_OPS=2 -> each total 12.
REQ-042 abort during cond2 WAIT -> IDLE next cycle, done=0, busy=0; subsequent start gives clean REQ-038 result.
REQ-043 prog_we while busy leaves table unchanged; start during DONE restarts with totals cleared.
